// File: rtl/binary_to_bcd_seq_pkg.sv
// binary_to_bcd_seq_pkg: shared digit width, FSM states and the digit-count legality check
package binary_to_bcd_seq_pkg;
    localparam int BCD_W = 4;
    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;
    // true when DIGITS decimal digits can represent 2**width-1
    function automatic bit digits_ok(int width, int digits);
        longint unsigned p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p > ((longint'(1) << width) - 1);
    endfunction
endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// binary_to_bcd_seq_if: Start/Bin request and Busy/Done/Bcd/Neg result bundle
//   master (calculator): drives Start, Bin; sees Busy, Done, Bcd, Neg
//   slave  (converter):  sees Start, Bin; drives Busy, Done, Bcd, Neg
interface binary_to_bcd_seq_if #(parameter int WIDTH = 8, parameter int DIGITS = 3);
    logic                  Start;
    logic [WIDTH-1:0]      Bin;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   Bcd;
    logic                  Neg;
    modport master (output Start, Bin, input Busy, Done, Bcd, Neg);
    modport slave (input Start, Bin, output Busy, Done, Bcd, Neg);
endinterface

// File: rtl/binary_to_bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction, d in, d+3 out when d >= 5
//   d  in  4  scratch digit
//   q  out 4  corrected digit
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: sequential double-dabble, WIDTH-bit binary to DIGITS packed BCD digits
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport: Start/Bin in, Busy/Done/Bcd/Neg out
//   BCD_SIGNED_EN: when defined Bin is two's complement, |Bin| is converted and Neg carries the sign
module binary_to_bcd_seq
    import binary_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input logic clk,
    input logic rst_n,
    binary_to_bcd_seq_if.slave bus
);
    localparam int SW = BCD_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    if (!digits_ok(WIDTH, DIGITS)) begin : g_chk
        $error("binary_to_bcd_seq: DIGITS too small for WIDTH");
    end
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  op;
    logic [SW-1:0]     scr;
    logic [SW-1:0]     adj;
    logic [SW-1:0]     bcd;
    logic [SW+WIDTH-1:0] sh;
    logic [WIDTH-1:0]  mag;
    logic              busy;
    logic              done;
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (.d(scr[BCD_W*g +: BCD_W]), .q(adj[BCD_W*g +: BCD_W]));
    end
    // corrected scratch and operand shift as one register pair
    assign sh = {adj, op} << 1;
`ifdef BCD_SIGNED_EN
    logic neg;
    logic neg_next;
    // WIDTH-bit negate keeps -2**(WIDTH-1) as its unsigned magnitude
    assign mag = bus.Bin[WIDTH-1] ? -bus.Bin : bus.Bin;
    assign bus.Neg = neg;
`else
    assign mag = bus.Bin;
    assign bus.Neg = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            scr   <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg      <= 1'b0;
            neg_next <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.Start) begin
                    op    <= mag;
                    scr   <= '0;
                    cnt   <= CW'(WIDTH);
                    busy  <= 1'b1;
                    state <= CONV;
`ifdef BCD_SIGNED_EN
                    neg_next <= bus.Bin[WIDTH-1];
`endif
                end
            end else begin
                op  <= sh[WIDTH-1:0];
                scr <= sh[SW+WIDTH-1:WIDTH];
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    bcd   <= sh[SW+WIDTH-1:WIDTH];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef BCD_SIGNED_EN
                    neg <= neg_next;
`endif
                end
            end
        end
    end
    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.Bcd  = bcd;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: directed literals plus randomized traffic against a cycle-level decimal model
module tb_binary_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    binary_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();
    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    int checks = 0;
    int errors = 0;
    bit        active, m_busy, m_done, m_neg;
    logic [11:0] m_bcd;
    logic [7:0]  val;
    int cyc = 0;
    int done_cyc = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction
    function automatic int magn(input logic [7:0] b);
`ifdef BCD_SIGNED_EN
        return b[7] ? 256 - int'(b) : int'(b);
`else
        return int'(b);
`endif
    endfunction
    function automatic bit sgn(input logic [7:0] b);
`ifdef BCD_SIGNED_EN
        return b[7];
`else
        return b[7] & 1'b0;
`endif
    endfunction
    // model: a request accepted at edge k yields its result at edge k+8; busy in between
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 0; m_busy = 0; m_done = 0; m_neg = 0; m_bcd = '0;
        end else begin
            cyc++;
            m_done = 0;
            if (active && cyc == done_cyc) begin
                active = 0;
                m_done = 1;
                m_bcd = to_bcd(magn(val));
                m_neg = sgn(val);
            end else if (!active && bus.Start) begin
                active = 1;
                done_cyc = cyc + 8;
                val = bus.Bin;
            end
            m_busy = active;
        end
    end
    always @(negedge clk)
        chk("cycle", {bus.Busy, bus.Done, bus.Neg, bus.Bcd}, {m_busy, m_done, m_neg, m_bcd});
    task automatic wait_done(output int n, output int b);
        n = 0;
        b = bus.Busy ? 1 : 0;
        while (!bus.Done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.Busy) b++;
        end
        chk("done_seen", bus.Done, 1);
    endtask
    task automatic run(input logic [7:0] v, input logic [11:0] e, input bit en, input string name);
        int n, b;
        bus.Start = 1; bus.Bin = v;
        @(posedge clk); #1;
        bus.Start = 0; bus.Bin = 8'($urandom);
        wait_done(n, b);
        chk({name, "_latency"}, n, 8);
        chk({name, "_busy"}, b, 8);
        chk(name, {en, bus.Bcd}, {en ? 1'b1 : 1'b0, e});
    endtask
    task automatic no_done(input string name);
        int d = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.Done) d++;
        end
        chk(name, d, 0);
    endtask
    initial begin
        int n, b;
        bus.Start = 0; bus.Bin = '0;
        repeat (2) @(posedge clk);
        #1 chk("reset", {bus.Busy, bus.Done, bus.Neg, bus.Bcd}, 0);
        rst_n = 1;
        @(posedge clk); #1;
`ifdef BCD_SIGNED_EN
        run(8'h80, 12'h128, 1, "s80");
        run(8'hFF, 12'h001, 1, "sFF");
        run(8'h7F, 12'h127, 0, "s7F");
        run(8'h00, 12'h000, 0, "s00");
`else
        run(8'd255, 12'h255, 0, "u255");
        run(8'd0, 12'h000, 0, "u0");
        run(8'd9, 12'h009, 0, "u9");
        run(8'd10, 12'h010, 0, "u10");
`endif
        bus.Start = 1; bus.Bin = 8'd100;
        @(posedge clk); #1;
        bus.Start = 0;
        repeat (2) begin @(posedge clk); #1; end
        bus.Start = 1; bus.Bin = 8'd7;
        @(posedge clk); #1;
        bus.Start = 0; bus.Bin = 8'd3;
        wait_done(n, b);
        chk("ignored_start", bus.Bcd, 12'h100);
        no_done("ignored_single_done");
        run(8'd99, 12'h099, 0, "b2b_first");
        run(8'd42, 12'h042, 0, "b2b_second");
        bus.Start = 1; bus.Bin = 8'd100;
        @(posedge clk); #1;
        bus.Start = 0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 0;
        #1 chk("reset_abort", {bus.Busy, bus.Done, bus.Neg, bus.Bcd}, 0);
        @(posedge clk); #1 rst_n = 1;
        no_done("reset_no_done");
        repeat (600) begin
            @(posedge clk); #1;
            bus.Start = $urandom_range(0, 2) == 0;
            bus.Bin = 8'($urandom);
            if ($urandom_range(0, 150) == 0) begin
                rst_n = 0;
                #1 rst_n = 1;
            end
        end
        bus.Start = 0;
        repeat (12) @(posedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
